// File: rtl/instr_exec_ctrl_pkg.sv
// instr_exec_ctrl_pkg: opcode constants, FSM state encoding and IR field positions
// shared by instr_exec_ctrl and its testbench-visible sub-blocks.
package instr_exec_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LI   = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_EXEC = 3'd2;
   localparam logic [2:0] S_WB   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int OP_HI  = 31;
   localparam int OP_LO  = 28;
   localparam int RD_HI  = 27;
   localparam int RD_LO  = 24;
   localparam int RS_HI  = 23;
   localparam int RS_LO  = 20;
   localparam int RT_HI  = 19;
   localparam int RT_LO  = 16;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   function automatic logic op_legal(input logic [3:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/instr_exec_ctrl_mul.sv
// shift_add_mul: iterative 16x16 multiplier keeping the low 16 product bits.
//   clk, rst      clock, async active-high reset
//   start         load a/b and clear the accumulator
//   a, b          multiplicand, multiplier
//   busy          iterating (16 cycles after start)
//   done          high during the last iteration cycle (counter at 15)
//   product       accumulator; final once busy drops
module shift_add_mul (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         // one multiplier bit per cycle, LSB first; counter wrap 15->0 ends the run
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : 16'h0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 4'd1;
         busy_d   = cnt_q != 4'hF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && cnt_q == 4'hF;
   assign product = acc_q;

endmodule

// File: rtl/instr_exec_ctrl.sv
// instr_exec_ctrl: serial single-instruction executor with a 16x16 register bank.
//   clk, rst            clock, async active-high reset
//   value               shared load bus for the instruction register
//   ld_ir_hi, ld_ir_lo  load IR[31:16] / IR[15:0] (IDLE only)
//   start               execute the held IR (IDLE only)
//   busy, done          not-IDLE, one-cycle completion pulse
//   illegal             last started opcode was illegal
//   zero, carry         ALU flags
//   display             last written-back value
module instr_exec_ctrl
   import instr_exec_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        ld_ir_hi,
   input  logic        ld_ir_lo,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        zero,
   output logic        carry,
   output logic [15:0] display
);

   logic [2:0]  state_q, state_d;
   logic [31:0] ir_q, ir_d, xir_q, xir_d;
   logic [15:0] a_q, a_d, b_q, b_d, display_q, display_d;
   logic        illegal_q, illegal_d, zero_q, zero_d, carry_q, carry_d;
   logic [15:0] regs_q [16];
   logic [15:0] regs_d [16];
   logic [3:0]  op, rd, rs, rt;
   logic [15:0] imm;
   logic [16:0] alu;
   logic        mul_start, mul_busy, mul_done;
   logic [15:0] mul_product;

   // xir holds the instruction being executed so IDLE loads issued with start
   // land in IR without disturbing the launched instruction
   assign op  = xir_q[OP_HI:OP_LO];
   assign rd  = xir_q[RD_HI:RD_LO];
   assign rs  = xir_q[RS_HI:RS_LO];
   assign rt  = xir_q[RT_HI:RT_LO];
   assign imm = xir_q[IMM_HI:IMM_LO];

   assign mul_start = state_q == S_READ && op == OP_MUL;

   shift_add_mul u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (regs_q[rs]),
      .b       (regs_q[rt]),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // bit 16 is the ADD/ADDI carry and, for SUB, the borrow (set iff a < b)
   always_comb begin
      alu = '0;
      case (op)
         OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
         OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
         OP_AND:  alu = {1'b0, a_q & b_q};
         OP_OR:   alu = {1'b0, a_q | b_q};
         OP_XOR:  alu = {1'b0, a_q ^ b_q};
         OP_ADDI: alu = {1'b0, a_q} + {1'b0, imm};
         OP_LI:   alu = {1'b0, imm};
         OP_SLL:  alu = {1'b0, a_q << imm[3:0]};
         OP_SRL:  alu = {1'b0, a_q >> imm[3:0]};
         OP_MUL:  alu = {1'b0, mul_product};
         default: alu = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      xir_d     = xir_q;
      a_d       = a_q;
      b_d       = b_q;
      illegal_d = illegal_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      display_d = display_q;
      regs_d    = regs_q;
      case (state_q)
         S_IDLE: begin
            ir_d = {ld_ir_hi ? value : ir_q[31:16], ld_ir_lo ? value : ir_q[15:0]};
            if (start) begin
               xir_d     = ir_q;
               illegal_d = 1'b0;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            a_d       = regs_q[rs];
            b_d       = regs_q[rt];
            illegal_d = !op_legal(op);
            state_d   = op_legal(op) ? S_EXEC : S_DONE;
         end
         S_EXEC: begin
            // an idle multiplier here can only mean it was never launched; leave rather than hang
            if (op != OP_MUL || mul_done || !mul_busy) state_d = S_WB;
         end
         S_WB: begin
            if (op != OP_NOP) begin
               if (rd != 4'd0) regs_d[rd] = alu[15:0];
               display_d = alu[15:0];
            end
            if (op != OP_NOP && op != OP_LI) begin
               zero_d  = alu[15:0] == 16'h0;
               carry_d = alu[16];
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         xir_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         illegal_q <= 1'b0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         display_q <= '0;
         for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         xir_q     <= xir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         illegal_q <= illegal_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         display_q <= display_d;
         regs_q    <= regs_d;
      end
   end

   assign busy    = state_q != S_IDLE;
   assign done    = state_q == S_DONE;
   assign illegal = illegal_q;
   assign zero    = zero_q;
   assign carry   = carry_q;
   assign display = display_q;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// tb_instr_exec_ctrl: directed and randomized checks of instr_exec_ctrl against an instruction-level model.
module tb_instr_exec_ctrl;

   logic        clk = 1'b0, rst = 1'b0;
   logic [15:0] value = '0;
   logic        ld_ir_hi = 1'b0, ld_ir_lo = 1'b0, start = 1'b0;
   logic        busy, done, illegal, zero, carry;
   logic [15:0] display;

   int checks = 0, errors = 0;

   logic [15:0] m_regs [16];
   logic [15:0] m_disp;
   logic        m_zero, m_carry, m_illegal;
   int          m_lat;

   instr_exec_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .ld_ir_hi (ld_ir_hi),
      .ld_ir_lo (ld_ir_lo),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .illegal  (illegal),
      .zero     (zero),
      .carry    (carry),
      .display  (display)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      foreach (m_regs[i]) m_regs[i] = '0;
      m_disp = '0; m_zero = 0; m_carry = 0; m_illegal = 0; m_lat = 0;
   endtask

   task automatic model_step(input logic [31:0] ir);
      int unsigned op, rd, rs, rt, imm, a, b, r;
      op = ir[31:28]; rd = ir[27:24]; rs = ir[23:20]; rt = ir[19:16]; imm = ir[15:0];
      a = m_regs[rs]; b = m_regs[rt];
      if (op > 10) begin m_illegal = 1; m_lat = 2; return; end
      m_illegal = 0;
      m_lat = (op == 10) ? 19 : 4;
      if (op == 0) return;
      case (op)
         1: r = a + b;
         2: r = a - b;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = a + imm;
         7: r = imm;
         8: r = a << (imm % 16);
         9: r = a >> (imm % 16);
         default: r = a * b;
      endcase
      if (rd != 0) m_regs[rd] = 16'(r);
      m_disp = 16'(r);
      if (op != 7) begin
         m_zero  = (r % 65536) == 0;
         m_carry = (op == 1 || op == 6) ? (r > 65535) : (op == 2) ? (a < b) : 1'b0;
      end
   endtask

   task automatic load_ir(input logic [31:0] ir);
      @(negedge clk); value = ir[31:16]; ld_ir_hi = 1;
      @(negedge clk); ld_ir_hi = 0; value = ir[15:0]; ld_ir_lo = 1;
      @(negedge clk); ld_ir_lo = 0;
   endtask

   // called at a negedge in IDLE; returns at the negedge where done is seen (or after the bound)
   task automatic launch(input logic lo_en, input logic [15:0] v, output int lat);
      start = 1; ld_ir_lo = lo_en; value = v;
      @(posedge clk); lat = 1;
      @(negedge clk); start = 0; ld_ir_lo = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
   endtask

   task automatic do_instr(input logic [31:0] ir, output int lat);
      load_ir(ir);
      model_step(ir);
      launch(1'b0, 16'h0, lat);
   endtask

   task automatic test_reset();
      #2 rst = 1;
      #1;
      checks++; if (busy !== 0 || done !== 0 || illegal !== 0) begin errors++; $display("FAIL reset_ctrl: got busy=%b done=%b illegal=%b expected 000", busy, done, illegal); end
      checks++; if (zero !== 0 || carry !== 0 || display !== 16'h0) begin errors++; $display("FAIL reset_data: got z=%b c=%b disp=%h expected 0 0 0000", zero, carry, display); end
      @(negedge clk); @(negedge clk); rst = 0;
      model_reset();
   endtask

   task automatic test_vectors();
      int lat;
      do_instr(32'h71000006, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL li_latency: got %0d expected 4", lat); end
      checks++; if (display !== 16'h0006 || zero !== 0 || carry !== 0) begin errors++; $display("FAIL li_r1: got disp=%h z=%b c=%b expected 0006 0 0", display, zero, carry); end
      do_instr(32'h72000001, lat);
      do_instr(32'h13120000, lat);
      checks++; if (display !== 16'h0007 || zero !== 0 || carry !== 0) begin errors++; $display("FAIL add: got disp=%h z=%b c=%b expected 0007 0 0", display, zero, carry); end
      do_instr(32'h24210000, lat);
      checks++; if (display !== 16'hFFFB || zero !== 0 || carry !== 1) begin errors++; $display("FAIL sub_borrow: got disp=%h z=%b c=%b expected fffb 0 1", display, zero, carry); end
      do_instr(32'h75000100, lat);
      do_instr(32'hA6550000, lat);
      checks++; if (lat !== 19) begin errors++; $display("FAIL mul_latency: got %0d expected 19", lat); end
      checks++; if (display !== 16'h0000 || zero !== 1 || carry !== 0) begin errors++; $display("FAIL mul_wrap: got disp=%h z=%b c=%b expected 0000 1 0", display, zero, carry); end
      do_instr(32'h75000003, lat);
      do_instr(32'hA6550000, lat);
      checks++; if (display !== 16'h0009 || zero !== 0) begin errors++; $display("FAIL mul_3x3: got disp=%h z=%b expected 0009 0", display, zero); end
   endtask

   task automatic test_illegal();
      int lat;
      do_instr(32'hF0000000, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency: got %0d expected 2", lat); end
      checks++; if (illegal !== 1 || display !== 16'h0009 || zero !== 0 || carry !== 0) begin errors++; $display("FAIL illegal_state: got ill=%b disp=%h z=%b c=%b expected 1 0009 0 0", illegal, display, zero, carry); end
      do_instr(32'h00000000, lat);
      checks++; if (illegal !== 0 || display !== 16'h0009 || lat !== 4) begin errors++; $display("FAIL nop_clears_illegal: got ill=%b disp=%h lat=%0d expected 0 0009 4", illegal, display, lat); end
   endtask

   task automatic test_busy_ignore();
      int lat;
      load_ir(32'h68800001);
      for (int k = 0; k < 2; k++) begin
         model_step(32'h68800001);
         start = 1;
         @(posedge clk); lat = 1;
         @(negedge clk); value = 16'hFFFF; ld_ir_hi = 1; ld_ir_lo = 1;
         while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); lat++;
            @(negedge clk);
         end
         start = 0; ld_ir_hi = 0; ld_ir_lo = 0;
         checks++; if (lat !== 4 || display !== m_disp) begin errors++; $display("FAIL busy_ignore_%0d: got lat=%0d disp=%h expected 4 %h", k, lat, display, m_disp); end
         @(negedge clk);
         checks++; if (busy !== 0 || done !== 0) begin errors++; $display("FAIL busy_ignore_idle_%0d: got busy=%b done=%b expected 0 0", k, busy, done); end
      end
   endtask

   task automatic test_load_with_start();
      int lat;
      load_ir(32'h79000055);
      model_step(32'h79000055);
      launch(1'b1, 16'h0077, lat);
      checks++; if (display !== 16'h0055) begin errors++; $display("FAIL load_with_start_old: got %h expected 0055", display); end
      @(negedge clk);
      model_step(32'h79000077);
      launch(1'b0, 16'h0, lat);
      checks++; if (display !== 16'h0077) begin errors++; $display("FAIL load_with_start_new: got %h expected 0077", display); end
      @(negedge clk); value = 16'h7171; ld_ir_hi = 1; ld_ir_lo = 1;
      @(negedge clk); ld_ir_hi = 0; ld_ir_lo = 0;
      model_step(32'h71717171);
      launch(1'b0, 16'h0, lat);
      checks++; if (display !== 16'h7171) begin errors++; $display("FAIL load_both_halves: got %h expected 7171", display); end
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      logic seen;
      load_ir(32'hA6550000);
      start = 1;
      @(posedge clk);
      @(negedge clk); start = 0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      #1 rst = 1;
      #1;
      checks++; if (busy !== 0 || done !== 0 || display !== 16'h0) begin errors++; $display("FAIL reset_mid_mul: got busy=%b done=%b disp=%h expected 0 0 0000", busy, done, display); end
      @(negedge clk); rst = 0;
      model_reset();
      seen = 0;
      repeat (20) begin @(negedge clk); if (done === 1'b1) seen = 1; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done: got done pulse %b expected 0", seen); end
      do_instr(32'h40600000, lat);
      checks++; if (display !== 16'h0000 || zero !== 1) begin errors++; $display("FAIL r6_cleared: got disp=%h z=%b expected 0000 1", display, zero); end
      do_instr(32'h77001234, lat);
      checks++; if (lat !== 4 || display !== 16'h1234) begin errors++; $display("FAIL li_after_reset: got lat=%0d disp=%h expected 4 1234", lat, display); end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] ir;
      for (int n = 0; n < 60; n++) begin
         ir = $urandom;
         if (n % 3 == 0) ir[31:28] = 4'(1 + $urandom_range(0, 9));
         if (n % 7 == 0) ir[15:0] = 16'(n * 31);
         do_instr(ir, lat);
         checks++; if (lat !== m_lat || display !== m_disp || zero !== m_zero || carry !== m_carry || illegal !== m_illegal)
            begin errors++; $display("FAIL random_%0d ir=%h: got lat=%0d disp=%h z=%b c=%b ill=%b expected %0d %h %b %b %b", n, ir, lat, display, zero, carry, illegal, m_lat, m_disp, m_zero, m_carry, m_illegal); end
         @(negedge clk);
         checks++; if (done !== 0 || busy !== 0) begin errors++; $display("FAIL random_pulse_%0d: got done=%b busy=%b expected 0 0", n, done, busy); end
      end
      for (int r = 1; r < 16; r++) begin
         model_step({4'd4, 4'd0, 4'(r), 4'd0, 16'h0});
         load_ir({4'd4, 4'd0, 4'(r), 4'd0, 16'h0});
         launch(1'b0, 16'h0, lat);
         checks++; if (display !== m_disp) begin errors++; $display("FAIL bank_r%0d: got %h expected %h", r, display, m_disp); end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_illegal();
      test_busy_ignore();
      test_load_with_start();
      test_reset_mid_mul();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_exec_ctrl.md
INSTR_EXEC_CTRL -- requirements
Module: instr_exec_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk (rising edge) and rst (asynchronous, active-high).
REQ-002 Ports, in order:
  clk      in   1   system clock
  rst      in   1   async reset, active-high
  value    in   16  shared load bus
  ld_ir_hi in   1   capture value into IR[31:16]
  ld_ir_lo in   1   capture value into IR[15:0]
  start    in   1   launch execution of held IR
  busy     out  1   high in every state except IDLE
  done     out  1   one-cycle completion pulse
  illegal  out  1   held high from DONE of an illegal opcode until the next start
  zero     out  1   ALU result == 0
  carry    out  1   ADD carry-out / SUB borrow
  display  out  16  last written-back value
REQ-003 IR fields SHALL be: op=IR[31:28], rd=IR[27:24], rs=IR[23:20], rt=IR[19:16], imm=IR[15:0].

Function
REQ-004 Register bank SHALL hold 16 x 16-bit registers; R0 SHALL always read as 0; writes to R0 SHALL be discarded.
REQ-005 Opcode map SHALL be:
- 0 NOP
- 1 ADD rd=rs+rt
- 2 SUB rd=rs-rt
- 3 AND
- 4 OR
- 5 XOR
- 6 ADDI rd=rs+imm
- 7 LI rd=imm
- 8 SLL rd=rs<<imm[3:0]
- 9 SRL rd=rs>>imm[3:0] (logical)
- 10 MUL rd=low16(rs*rt)
- 11-15 illegal.
REQ-006 All arithmetic SHALL be 16-bit modulo 2^16. ADD/ADDI carry = bit 16 of the unsigned sum. SUB carry = 1 iff rs<rt unsigned.
REQ-007 zero and carry SHALL update only at WB of opcodes 1-6 and 8-10; carry SHALL be written 0 for all of these except ADD/ADDI/SUB. Flags SHALL hold for NOP, LI, and illegal opcodes.
REQ-008 FSM states SHALL be IDLE, READ, EXEC, WB, DONE:
- IDLE->READ on start.
- READ: latch A=R[rs], B=R[rt], decode; ->EXEC, or ->DONE if op is illegal.
- EXEC: ->WB after 1 cycle, or after 16 cycles for MUL.
- WB: write rd (if op is not NOP), update display; ->DONE.
- DONE: done=1; ->IDLE.
REQ-009 Latency: done SHALL be high in the cycle after the 4th rising edge, counting the edge that samples start, for non-MUL ops. For MUL it SHALL be the cycle after the 19th edge. Illegal ops SHALL complete after the 2nd edge.
REQ-010 MUL SHALL be iterative shift-add, one multiplier bit per EXEC cycle, LSB first, driven by a 4-bit counter that wraps 15->0 to end EXEC.
REQ-011 start SHALL be ignored outside IDLE. start and done in the same cycle SHALL be impossible, because DONE always returns to IDLE first.
REQ-012 ld_ir_hi/ld_ir_lo SHALL be honoured only in IDLE and ignored otherwise. If asserted together with start, the load SHALL take effect and execution SHALL use the previously held IR.
REQ-013 Simultaneous ld_ir_hi and ld_ir_lo SHALL write value into both halves.
REQ-014 A write to rd SHALL be visible to a READ of the next instruction; no bypass is needed, because the ops are strictly serial.
REQ-015 display SHALL change only at WB with the written value, including when rd=0. When rd=0 the bank SHALL remain unchanged.

Reset
REQ-016 rst SHALL immediately force: state IDLE; IR, all registers, A, B, and MUL accumulator/counter to 0; busy, done, illegal, zero, carry to 0; display to 0000.
REQ-017 rst asserted mid-operation SHALL abort the instruction with no register write and no done pulse. The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-018 A shared package SHALL hold the opcode constants, the FSM state encoding, and the IR field bit positions.
REQ-019 The iterative multiplier SHALL be a sub-module, shift_add_mul, with ports start/a/b/busy/done/product. ALU and bank SHALL remain inside instr_exec_ctrl.

Verification
REQ-020 LI R1,0x0006 (IR=0x71000006), then start: done after 4 edges, display=0006, zero/carry unchanged (0).
REQ-021 LI R2,0x0001; ADD R3,R1,R2 (0x13120000): display=0007, zero=0, carry=0. Then SUB R4,R2,R1 (0x24210000): display=FFFB, carry=1.
REQ-022 LI R5,0x0100; MUL R6,R5,R5 (0xA6550000): done after 19 edges, display=0000, zero=1. With R5=0x0003, MUL gives display=0009.
REQ-023 Illegal opcode IR=0xF0000000: done after 2 edges, illegal=1, bank/display/flags unchanged. start held high during busy and ld_ir_* pulsed during busy: no effect.
REQ-024 rst pulsed during the MUL EXEC cycle 8: busy=0 and done stays 0 immediately, R6 reads 0. A following LI R7,0x1234 completes with display=1234.
